alux_arbiter: RTL

//  Shares one ALUX complex-arithmetic unit between two requesters (req0, req1).
//  - Arbitrates between the requesters round-robin.
//  - Holds the granted operands and opcode stable while ALUX works.
//  - Drives the ALUX start level until ALUX reports done.
//  - Returns the 64-bit result on a shared response bus, tagged with the requester id.
//  - A watchdog aborts unsupported or hung operations so a requester never stalls forever.

---
 rtl/alux_arbiter_if.sv | 43 ++++
 rtl/alux_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alux_arbiter_if.sv
// Requester, response and ALUX-side signal bundle for alux_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alux_arbiter_if;
    logic        req0_valid;
    logic [3:0]  req0_opr;
    logic [63:0] req0_inA;
    logic [63:0] req0_inB;
    logic        req0_ack;
    logic        req1_valid;
    logic [3:0]  req1_opr;
    logic [63:0] req1_inA;
    logic [63:0] req1_inB;
    logic        req1_ack;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_id;
    logic        resp_err;
    logic        busy;
    logic [63:0] alux_inA;
    logic [63:0] alux_inB;
    logic [3:0]  alux_opr;
    logic        alux_start;
    logic [63:0] alux_outAB;
    logic        alux_done;

    modport slave (
        input  req0_valid, req0_opr, req0_inA, req0_inB,
        input  req1_valid, req1_opr, req1_inA, req1_inB,
        input  alux_outAB, alux_done,
        output req0_ack, req1_ack,
        output resp_valid, resp_data, resp_id, resp_err, busy,
        output alux_inA, alux_inB, alux_opr, alux_start
    );

    modport master (
        output req0_valid, req0_opr, req0_inA, req0_inB,
        output req1_valid, req1_opr, req1_inA, req1_inB,
        output alux_outAB, alux_done,
        input  req0_ack, req1_ack,
        input  resp_valid, resp_data, resp_id, resp_err, busy,
        input  alux_inA, alux_inB, alux_opr, alux_start
    );
endinterface

// File: rtl/alux_arbiter.sv
// Round-robin arbiter sharing one ALUX unit between two requesters, with a
// watchdog that aborts operations ALUX never completes.
module alux_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int SETUP   = 1
) (
    input  logic          clock,
    input  logic          reset,
    alux_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int SU_W = (SETUP > 1) ? $clog2(SETUP) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [SU_W-1:0] SU_LAST  = SU_W'(SETUP - 1);

    logic [2:0]      state_r;
    logic [2:0]      state_nx_s;
    logic [WD_W-1:0] wdog_r;
    logic [SU_W-1:0] setup_cnt_r;
    logic            ptr_r;
    logic            id_r;
    logic            grant_s;
    logic            any_valid_s;
    logic            wd_expired_s;

    logic            ack0_r;
    logic            ack1_r;
    logic            resp_valid_r;
    logic [63:0]     resp_data_r;
    logic            resp_id_r;
    logic            resp_err_r;
    logic            busy_r;
    logic [63:0]     inA_r;
    logic [63:0]     inB_r;
    logic [3:0]      opr_r;
    logic            start_r;

    // Grant selection: a lone requester wins, otherwise the pointer decides.
    always_comb begin
        any_valid_s  = bus.req0_valid | bus.req1_valid;
        wd_expired_s = (wdog_r == WD_LIMIT);
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ptr_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic; a done seen on the timeout cycle takes precedence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = any_valid_s ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_nx_s = (setup_cnt_r == SU_LAST) ? ST_WAIT : ST_SETUP;
            ST_WAIT: begin
                if (bus.alux_done) begin
                    state_nx_s = ST_DRAIN;
                end else if (wd_expired_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DRAIN: state_nx_s = ST_RESP;
            ST_RESP:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register, priority pointer, setup counter and watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wdog_r      <= {WD_W{1'b0}};
            setup_cnt_r <= {SU_W{1'b0}};
            ptr_r       <= 1'b0;
            id_r        <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    setup_cnt_r <= {SU_W{1'b0}};
                    wdog_r      <= {WD_W{1'b0}};
                    if (any_valid_s) begin
                        ptr_r <= ~grant_s;
                        id_r  <= grant_s;
                    end
                end
                ST_SETUP: setup_cnt_r <= setup_cnt_r + SU_W'(1'b1);
                ST_WAIT: begin
                    if (!bus.alux_done && !wd_expired_s) begin
                        wdog_r <= wdog_r + WD_W'(1'b1);
                    end
                end
                ST_RESP:  wdog_r <= {WD_W{1'b0}};
                default:  wdog_r <= wdog_r;
            endcase
        end
    end

    // Registered outputs toward requesters, response bus and ALUX.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 64'd0;
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            inA_r        <= 64'd0;
            inB_r        <= 64'd0;
            opr_r        <= 4'd0;
            start_r      <= 1'b0;
        end else begin
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= (state_nx_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        ack0_r <= ~grant_s;
                        ack1_r <= grant_s;
                        inA_r  <= grant_s ? bus.req1_inA : bus.req0_inA;
                        inB_r  <= grant_s ? bus.req1_inB : bus.req0_inB;
                        opr_r  <= grant_s ? bus.req1_opr : bus.req0_opr;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt_r == SU_LAST) begin
                        start_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.alux_done) begin
                        start_r <= 1'b0;
                    end else if (wd_expired_s) begin
                        start_r     <= 1'b0;
                        resp_err_r  <= 1'b1;
                        resp_data_r <= 64'd0;
                    end
                end
                // ALUX presents its result one cycle after done
                ST_DRAIN: begin
                    resp_data_r <= bus.alux_outAB;
                    resp_err_r  <= 1'b0;
                end
                ST_RESP: begin
                    resp_valid_r <= 1'b1;
                    resp_id_r    <= id_r;
                end
                default: start_r <= 1'b0;
            endcase
        end
    end

    assign bus.req0_ack   = ack0_r;
    assign bus.req1_ack   = ack1_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.busy       = busy_r;
    assign bus.alux_inA   = inA_r;
    assign bus.alux_inB   = inB_r;
    assign bus.alux_opr   = opr_r;
    assign bus.alux_start = start_r;
endmodule
